// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage and its F/D pipeline register.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    BUF     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fd_pipe_reg.sv
// Fetch/Decode pipeline register: flush beats stall beats load; no load inserts a bubble.
module fd_pipe_reg
  import fetch_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         stall,
  input  logic         load,
  input  logic [W-1:0] next_instr,
  output logic [W-1:0] instr,
  output logic         valid
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr <= W'(NOP_INSTR);
      valid <= 1'b0;
    end else if (flush) begin
      instr <= W'(NOP_INSTR);
      valid <= 1'b0;
    end else if (!stall) begin
      if (load) begin
        instr <= next_instr;
        valid <= 1'b1;
      end else begin
        instr <= W'(NOP_INSTR);
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns PCF, talks to instruction memory, buffers words the pipeline cannot take.
// Optional performance counters are enabled with FETCH_PERF_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              BranchTakenE,
  input  logic [DATA_W-1:0] ALUResultE,
  input  logic              PCSrcW,
  input  logic [DATA_W-1:0] ResultW,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              ImemWaitF,
  output logic [DATA_W-1:0] InstrD,
  output logic [DATA_W-1:0] PCPlus8D,
  output logic              ValidD
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_wait_cycles,
  output logic [15:0]       perf_redirects
`endif
);

  fetch_state_t      state_reg, state_next;
  logic [DATA_W-1:0] pcf_reg, pcf_next;
  logic [DATA_W-1:0] buf_reg, buf_next;
  logic [DATA_W-1:0] stale_addr_reg, stale_addr_next;

  logic              avail, accept, redirect;
  logic [DATA_W-1:0] target, pc_plus4, instr_src;

  assign avail     = ((state_reg == FETCH) && imem_ready) || (state_reg == BUF);
  assign accept    = avail && !StallF && !StallD && !FlushD;
  assign redirect  = BranchTakenE || PCSrcW;
  assign target    = BranchTakenE ? ALUResultE : ResultW;
  assign pc_plus4  = pcf_reg + DATA_W'(4);
  assign instr_src = (state_reg == BUF) ? buf_reg : imem_rdata;

  // While discarding, the memory still owns the old address until it answers.
  assign imem_addr = (state_reg == DISCARD) ? stale_addr_reg : pcf_reg;
  assign imem_req  = reset_n && (state_reg != BUF);
  assign ImemWaitF = !avail;
  assign PCPlus8D  = pc_plus4;

  always_comb begin
    state_next      = state_reg;
    buf_next        = buf_reg;
    stale_addr_next = stale_addr_reg;
    unique case (state_reg)
      FETCH: begin
        if (redirect) begin
          if (!imem_ready) begin
            state_next      = DISCARD;
            stale_addr_next = pcf_reg;
          end
        end else if (imem_ready && !accept) begin
          state_next = BUF;
          buf_next   = imem_rdata;
        end
      end
      BUF: begin
        if (redirect || accept) state_next = FETCH;
      end
      DISCARD: begin
        if (imem_ready) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    pcf_next = pcf_reg;
    if (redirect)    pcf_next = target;
    else if (accept) pcf_next = pc_plus4;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= FETCH;
      pcf_reg        <= RESET_PC;
      buf_reg        <= DATA_W'(NOP_INSTR);
      stale_addr_reg <= RESET_PC;
    end else begin
      state_reg      <= state_next;
      pcf_reg        <= pcf_next;
      buf_reg        <= buf_next;
      stale_addr_reg <= stale_addr_next;
    end
  end

  fd_pipe_reg #(
    .W(DATA_W)
  ) u_fd_pipe_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (FlushD),
    .stall     (StallD),
    .load      (accept),
    .next_instr(instr_src),
    .instr     (InstrD),
    .valid     (ValidD)
  );

`ifdef FETCH_PERF_EN
  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_wait_cycles <= '0;
      perf_redirects   <= '0;
    end else begin
      if (!avail && (perf_wait_cycles != '1)) perf_wait_cycles <= perf_wait_cycles + 32'd1;
      if (redirect && (perf_redirects != '1)) perf_redirects <= perf_redirects + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage; memory data is 32'hE000_0000 | address.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        StallF, StallD, FlushD, BranchTakenE, PCSrcW;
  logic [31:0] ALUResultE, ResultW;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        ImemWaitF;
  logic [31:0] InstrD, PCPlus8D;
  logic        ValidD;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_wait_cycles;
  logic [15:0] perf_redirects;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_rdata = 32'hE000_0000 | imem_addr;

  fetch_stage dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .StallF      (StallF),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .BranchTakenE(BranchTakenE),
    .ALUResultE  (ALUResultE),
    .PCSrcW      (PCSrcW),
    .ResultW     (ResultW),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .ImemWaitF   (ImemWaitF),
    .InstrD      (InstrD),
    .PCPlus8D    (PCPlus8D),
    .ValidD      (ValidD)
`ifdef FETCH_PERF_EN
    ,
    .perf_wait_cycles(perf_wait_cycles),
    .perf_redirects  (perf_redirects)
`endif
  );

  task automatic clear_inputs();
    StallF = 0; StallD = 0; FlushD = 0;
    BranchTakenE = 0; PCSrcW = 0;
    ALUResultE = 32'h0; ResultW = 32'h0;
    imem_ready = 0;
  endtask

  // Leaves the bench one time unit past a rising edge, with reset released.
  task automatic do_reset();
    reset_n = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    clear_inputs();
    imem_ready = 1;
    @(posedge clk);
    #2;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", ValidD); end
    checks++; if (InstrD !== 32'h0) begin errors++; $display("FAIL rst_instr got=%h exp=00000000", InstrD); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h exp=00000000", imem_addr); end
    @(posedge clk);
    #1 reset_n = 1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL c0_req got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL c0_addr got=%h exp=00000000", imem_addr); end
    checks++; if (PCPlus8D !== 32'h4) begin errors++; $display("FAIL c0_pc8 got=%h exp=00000004", PCPlus8D); end
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL c0_valid got=%b exp=0", ValidD); end
    next_cycle(); @(negedge clk);
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL c1_addr got=%h exp=00000004", imem_addr); end
    checks++; if (ValidD !== 1'b1) begin errors++; $display("FAIL c1_valid got=%b exp=1", ValidD); end
    checks++; if (InstrD !== 32'hE000_0000) begin errors++; $display("FAIL c1_instr got=%h exp=e0000000", InstrD); end
    next_cycle(); @(negedge clk);
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL c2_addr got=%h exp=00000008", imem_addr); end
    checks++; if (InstrD !== 32'hE000_0004) begin errors++; $display("FAIL c2_instr got=%h exp=e0000004", InstrD); end
    checks++; if (PCPlus8D !== 32'hC) begin errors++; $display("FAIL c2_pc8 got=%h exp=0000000c", PCPlus8D); end
    $display("test_reset done: streaming fetch 0,4,8");
  endtask

  task automatic test_wait();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (ImemWaitF !== 1'b1) begin errors++; $display("FAIL wait_flag[%0d] got=%b exp=1", c, ImemWaitF); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wait_addr[%0d] got=%h exp=00000000", c, imem_addr); end
      checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL wait_valid[%0d] got=%b exp=0", c, ValidD); end
      next_cycle();
    end
    imem_ready = 1;
    @(negedge clk);
    checks++; if (ImemWaitF !== 1'b0) begin errors++; $display("FAIL ready_flag got=%b exp=0", ImemWaitF); end
    next_cycle();
    imem_ready = 0;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL after_ready_addr got=%h exp=00000004", imem_addr); end
    checks++; if (InstrD !== 32'hE000_0000 || ValidD !== 1'b1) begin errors++; $display("FAIL after_ready_d got=%h/%b exp=e0000000/1", InstrD, ValidD); end
    next_cycle(); @(negedge clk);
    checks++; if (ValidD !== 1'b0 || InstrD !== 32'h0) begin errors++; $display("FAIL bubble_d got=%h/%b exp=00000000/0", InstrD, ValidD); end
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL bubble_addr got=%h exp=00000004", imem_addr); end
    $display("test_wait done: 3-cycle memory latency");
  endtask

  task automatic test_stall_buffer();
    do_reset();
    imem_ready = 1;
    next_cycle();
    StallF = 1; StallD = 1;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL sb_addr1 got=%h exp=00000004", imem_addr); end
    next_cycle(); @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL sb_req_buf got=%b exp=0", imem_req); end
    checks++; if (ImemWaitF !== 1'b0) begin errors++; $display("FAIL sb_wait_buf got=%b exp=0", ImemWaitF); end
    checks++; if (InstrD !== 32'hE000_0000 || ValidD !== 1'b1) begin errors++; $display("FAIL sb_hold got=%h/%b exp=e0000000/1", InstrD, ValidD); end
    next_cycle();
    StallF = 0; StallD = 0; imem_ready = 0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h4) begin errors++; $display("FAIL sb_release got=%b/%h exp=0/00000004", imem_req, imem_addr); end
    next_cycle(); @(negedge clk);
    checks++; if (InstrD !== 32'hE000_0004 || ValidD !== 1'b1) begin errors++; $display("FAIL sb_drain got=%h/%b exp=e0000004/1", InstrD, ValidD); end
    checks++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin errors++; $display("FAIL sb_next got=%h/%b exp=00000008/1", imem_addr, imem_req); end
    $display("test_stall_buffer done: buffered word drained after stall");
  endtask

  task automatic test_discard();
    do_reset();
    BranchTakenE = 1; ALUResultE = 32'h100;
    next_cycle();
    BranchTakenE = 0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL dc_old got=%b/%h exp=1/00000000", imem_req, imem_addr); end
    checks++; if (ImemWaitF !== 1'b1) begin errors++; $display("FAIL dc_wait got=%b exp=1", ImemWaitF); end
    next_cycle();
    imem_ready = 1;
    @(negedge clk);
    checks++; if (ImemWaitF !== 1'b1) begin errors++; $display("FAIL dc_stale_wait got=%b exp=1", ImemWaitF); end
    next_cycle(); @(negedge clk);
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL dc_target got=%h exp=00000100", imem_addr); end
    checks++; if (ValidD !== 1'b0 || InstrD !== 32'h0) begin errors++; $display("FAIL dc_dropped got=%h/%b exp=00000000/0", InstrD, ValidD); end
    next_cycle(); @(negedge clk);
    checks++; if (InstrD !== 32'hE000_0100 || ValidD !== 1'b1) begin errors++; $display("FAIL dc_first got=%h/%b exp=e0000100/1", InstrD, ValidD); end
    checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL dc_next got=%h exp=00000104", imem_addr); end
    $display("test_discard done: stale response dropped");
  endtask

  task automatic test_dual_redirect();
    do_reset();
    imem_ready = 1;
    next_cycle();
    BranchTakenE = 1; ALUResultE = 32'h200;
    PCSrcW = 1; ResultW = 32'h300; FlushD = 1;
    next_cycle();
    BranchTakenE = 0; FlushD = 0;
    PCSrcW = 1; ResultW = 32'h300; StallF = 1; StallD = 1;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL dr_prio got=%h exp=00000200", imem_addr); end
    checks++; if (InstrD !== 32'h0 || ValidD !== 1'b0) begin errors++; $display("FAIL dr_flush got=%h/%b exp=00000000/0", InstrD, ValidD); end
    checks++; if (PCPlus8D !== 32'h204) begin errors++; $display("FAIL dr_pc8 got=%h exp=00000204", PCPlus8D); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if (imem_addr !== 32'h300) begin errors++; $display("FAIL dr_stallf got=%h exp=00000300", imem_addr); end
    $display("test_dual_redirect done: branch beats writeback");
  endtask

  task automatic test_wrap();
    do_reset();
    imem_ready = 1;
    PCSrcW = 1; ResultW = 32'hFFFF_FFFC;
    next_cycle();
    PCSrcW = 0;
    @(negedge clk);
    checks++; if (imem_addr !== 32'hFFFF_FFFC || PCPlus8D !== 32'h0) begin errors++; $display("FAIL wrap_top got=%h/%h exp=fffffffc/00000000", imem_addr, PCPlus8D); end
    next_cycle(); @(negedge clk);
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got=%h exp=00000000", imem_addr); end
    checks++; if (InstrD !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_instr got=%h exp=fffffffc", InstrD); end
    $display("test_wrap done: PC wraps to zero");
  endtask

  task automatic test_reset_discard();
    do_reset();
    BranchTakenE = 1; ALUResultE = 32'h100;
    next_cycle();
    BranchTakenE = 0;
    reset_n = 0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rd_req got=%b exp=0", imem_req); end
    checks++; if (PCPlus8D !== 32'h4) begin errors++; $display("FAIL rd_pc got=%h exp=00000004", PCPlus8D); end
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL rd_valid got=%b exp=0", ValidD); end
    @(posedge clk);
    #1 reset_n = 1;
    imem_ready = 1;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL rd_restart got=%h/%b exp=00000000/1", imem_addr, imem_req); end
    next_cycle(); @(negedge clk);
    checks++; if (imem_addr !== 32'h4 || InstrD !== 32'hE000_0000) begin errors++; $display("FAIL rd_stream got=%h/%h exp=00000004/e0000000", imem_addr, InstrD); end
    $display("test_reset_discard done: reset aborts discard");
  endtask

  initial begin
    test_reset();
    test_wait();
    test_stall_buffer();
    test_discard();
    test_dual_redirect();
    test_wrap();
    test_reset_discard();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
